// File: rtl/lwb_pkg.sv
// Shared defaults and index helpers for line_window_buffer and its line memories.
package lwb_pkg;

    localparam int LWB_COORD_W = 11;

    function automatic int lwb_clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // (base + k) mod n for base, k < n; avoids a general divider.
    function automatic int lwb_mod_idx(input int base, input int k, input int n);
        int sum;
        sum = base + k;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/lwb_line_ram.sv
// One line of pixel storage: single port, clock enable, read-before-write.
module lwb_line_ram
    import lwb_pkg::*;
#(
    parameter int DEPTH = 420,
    parameter int WIDTH = 8,
    parameter int AW    = lwb_clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_d;
    logic [WIDTH-1:0] rd_q;

    // Read data captures the old contents on an enabled access, else holds.
    always_comb begin
        rd_d = rd_q;
        if (ce) begin
            rd_d = mem[addr];
        end else begin
            rd_d = rd_q;
        end
    end

    // Read register is cleared so the column output starts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Storage array itself is never reset.
    always_ff @(posedge clock) begin
        if (ce && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/line_window_buffer.sv
// Raster stream to vertical pixel column using ROWS-1 rotating line memories.
// Define LWB_TOP_REPLICATE_EN to emit columns from line 0 with top-border replication.
module line_window_buffer
    import lwb_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int LINE_W  = 420,
    parameter int ROWS    = 5,
    parameter int COORD_W = LWB_COORD_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PIXEL_W-1:0]      din,
    input  logic                    validin,
    input  logic                    sof,
    output logic [ROWS*PIXEL_W-1:0] dout,
    output logic                    validout,
    output logic [COORD_W-1:0]      col_out,
    output logic [COORD_W-1:0]      row_out
);

    localparam int NM  = ROWS - 1;
    localparam int AW  = lwb_clog2(LINE_W);
    localparam int WPW = lwb_clog2(NM);
    localparam int LDW = lwb_clog2(ROWS);

    localparam logic [AW-1:0]      COL_LAST = AW'(LINE_W - 1);
    localparam logic [WPW-1:0]     WP_LAST  = WPW'(NM - 1);
    localparam logic [LDW-1:0]     LD_FULL  = LDW'(NM);
    localparam logic [COORD_W-1:0] ROW_MAX  = '1;

    logic [AW-1:0]      col_q, col_d, col_eff_s;
    logic [WPW-1:0]     wptr_q, wptr_d, sel_q, sel_d;
    logic [LDW-1:0]     ld_q, ld_d, ld_eff_s;
    logic [COORD_W-1:0] row_q, row_d, row_eff_s;
    logic [PIXEL_W-1:0] din_q, din_d;
    logic               validout_q, validout_d;
    logic [COORD_W-1:0] col_out_q, col_out_d, row_out_q, row_out_d;

    logic [PIXEL_W-1:0]      rd_s    [NM];
    logic [PIXEL_W-1:0]      slice_s [ROWS];
    logic [ROWS*PIXEL_W-1:0] dout_s;

`ifdef LWB_TOP_REPLICATE_EN
    logic [LDW-1:0] ldo_q, ldo_d;
    logic [LDW-1:0] rep_s;
`endif

    // Per-pixel control: sof forces line 0 / column 0 and an empty history.
    always_comb begin
        col_eff_s  = sof ? '0 : col_q;
        ld_eff_s   = sof ? '0 : ld_q;
        row_eff_s  = sof ? '0 : row_q;
        col_d      = col_q;
        wptr_d     = wptr_q;
        ld_d       = ld_q;
        row_d      = row_q;
        sel_d      = sel_q;
        din_d      = din_q;
        col_out_d  = col_out_q;
        row_out_d  = row_out_q;
`ifdef LWB_TOP_REPLICATE_EN
        ldo_d      = ldo_q;
        validout_d = validin;
`else
        validout_d = validin & (ld_eff_s == LD_FULL);
`endif
        if (validin) begin
            din_d     = din;
            sel_d     = wptr_q;
            col_out_d = COORD_W'(col_eff_s);
            row_out_d = row_eff_s;
`ifdef LWB_TOP_REPLICATE_EN
            ldo_d     = ld_eff_s;
`endif
            if (col_eff_s == COL_LAST) begin
                col_d  = '0;
                wptr_d = (wptr_q == WP_LAST) ? '0 : (wptr_q + WPW'(1));
                ld_d   = (ld_eff_s == LD_FULL) ? ld_eff_s : (ld_eff_s + LDW'(1));
                row_d  = (row_eff_s == ROW_MAX) ? row_eff_s : (row_eff_s + COORD_W'(1));
            end else begin
                col_d  = col_eff_s + AW'(1);
                wptr_d = wptr_q;
                ld_d   = ld_eff_s;
                row_d  = row_eff_s;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Control state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q      <= '0;
            wptr_q     <= '0;
            ld_q       <= '0;
            row_q      <= '0;
            sel_q      <= '0;
            din_q      <= '0;
            validout_q <= 1'b0;
            col_out_q  <= '0;
            row_out_q  <= '0;
`ifdef LWB_TOP_REPLICATE_EN
            ldo_q      <= '0;
`endif
        end else begin
            col_q      <= col_d;
            wptr_q     <= wptr_d;
            ld_q       <= ld_d;
            row_q      <= row_d;
            sel_q      <= sel_d;
            din_q      <= din_d;
            validout_q <= validout_d;
            col_out_q  <= col_out_d;
            row_out_q  <= row_out_d;
`ifdef LWB_TOP_REPLICATE_EN
            ldo_q      <= ldo_d;
`endif
        end
    end

    // Memory sel_q+k (captured with the pixel) holds the line NM-k lines back.
    for (genvar k = 0; k < NM; k++) begin : g_mem
        lwb_line_ram #(
            .DEPTH (LINE_W),
            .WIDTH (PIXEL_W),
            .AW    (AW)
        ) u_ram (
            .clock (clock),
            .reset (reset),
            .ce    (validin),
            .we    (wptr_q == WPW'(k)),
            .addr  (col_eff_s),
            .wdata (din),
            .rdata (rd_s[k])
        );
        assign slice_s[k] = rd_s[WPW'(lwb_mod_idx(int'(sel_q), k, NM))];
    end
    assign slice_s[NM] = din_q;

`ifdef LWB_TOP_REPLICATE_EN
    assign rep_s = LD_FULL - ldo_q;
`endif

    for (genvar i = 0; i < ROWS; i++) begin : g_out
`ifdef LWB_TOP_REPLICATE_EN
        assign dout_s[i*PIXEL_W +: PIXEL_W] = ((NM - i) > int'(ldo_q)) ? slice_s[rep_s] : slice_s[i];
`else
        assign dout_s[i*PIXEL_W +: PIXEL_W] = slice_s[i];
`endif
    end

    assign dout     = dout_s;
    assign validout = validout_q;
    assign col_out  = col_out_q;
    assign row_out  = row_out_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Randomised and directed bench for line_window_buffer with a queue-of-lines reference model.
module tb_line_window_buffer;

    localparam int PIXEL_W = 8;
    localparam int LINE_W  = 8;
    localparam int ROWS    = 5;
    localparam int COORD_W = 11;
`ifdef LWB_TOP_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [PIXEL_W-1:0]      din = '0;
    logic                    validin = 1'b0;
    logic                    sof = 1'b0;
    logic [ROWS*PIXEL_W-1:0] dout;
    logic                    validout;
    logic [COORD_W-1:0]      col_out;
    logic [COORD_W-1:0]      row_out;

    line_window_buffer #(
        .PIXEL_W (PIXEL_W),
        .LINE_W  (LINE_W),
        .ROWS    (ROWS),
        .COORD_W (COORD_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .validin  (validin),
        .sof      (sof),
        .dout     (dout),
        .validout (validout),
        .col_out  (col_out),
        .row_out  (row_out)
    );

    always #5 clock = ~clock;

    int nt = 0;
    int nf = 0;
    int gl = 0;
    int gc = 0;

    // Reference model: complete lines received since the frame start.
    typedef logic [PIXEL_W-1:0] line_t [LINE_W];
    line_t done_q[$];
    line_t cur_line;
    int    m_col, m_row;
    logic [ROWS*PIXEL_W-1:0] exp_dout;
    logic                    exp_valid, exp_known;
    logic [COORD_W-1:0]      exp_col, exp_row;

    task automatic model_reset();
        done_q.delete();
        m_col = 0; m_row = 0;
        exp_valid = 1'b0; exp_known = 1'b1;
        exp_dout = '0; exp_col = '0; exp_row = '0;
    endtask

    task automatic model_accept(input logic s, input logic [PIXEL_W-1:0] d);
        int ld, j;
        if (s) begin
            done_q.delete();
            m_col = 0; m_row = 0;
        end
        ld = done_q.size();
        cur_line[m_col] = d;
        exp_valid = REPL ? 1'b1 : (ld == ROWS - 1);
        exp_known = exp_valid;
        exp_col = COORD_W'(m_col);
        exp_row = COORD_W'(m_row);
        if (exp_valid) begin
            for (int i = 0; i < ROWS; i++) begin
                j = ROWS - 1 - i;
                if (j > ld) j = ld;
                if (j == 0) exp_dout[i*PIXEL_W +: PIXEL_W] = d;
                else        exp_dout[i*PIXEL_W +: PIXEL_W] = done_q[ld - j][m_col];
            end
        end
        if (m_col == LINE_W - 1) begin
            done_q.push_back(cur_line);
            if (done_q.size() > ROWS - 1) void'(done_q.pop_front());
            m_col = 0;
            if (m_row < (1 << COORD_W) - 1) m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [PIXEL_W-1:0] d);
        validin = v; sof = s; din = d;
        @(posedge clock);
        if (v) model_accept(s, d);
        else   exp_valid = 1'b0;
        #1;
        validin = 1'b0; sof = 1'b0;
    endtask

    // Sends the next raster pixel 16*line+col; sof restarts the generator.
    task automatic send(input logic s);
        if (s) begin gl = 0; gc = 0; end
        drive(1'b1, s, PIXEL_W'(16 * gl + gc));
        gc++;
        if (gc == LINE_W) begin gc = 0; gl++; end
    endtask

    task automatic test_reset();
        #12;
        nt++;
        if ({dout, validout, col_out, row_out} !== '0) begin
            nf++; $display("FAIL reset_held: got %h/%0b/%0d/%0d, want all zero", dout, validout, col_out, row_out);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        nt++;
        if ({dout, validout, col_out, row_out} !== '0) begin
            nf++; $display("FAIL reset_idle: got %h/%0b/%0d/%0d, want all zero", dout, validout, col_out, row_out);
        end
    endtask

    task automatic test_fill_window();
        for (int p = 0; p < 35; p++) begin
            send(p == 0);
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL fill p=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", p, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
`ifdef LWB_TOP_REPLICATE_EN
            if (p == 0 || p == 11) begin
                nt++;
                if (validout !== 1'b1 || dout !== ((p == 0) ? 40'h00_00_00_00_00 : 40'h13_03_03_03_03)) begin
                    nf++; $display("FAIL replicate p=%0d: got v=%0b d=%h", p, validout, dout);
                end
            end
`else
            if (p == 34) begin
                nt++;
                if (validout !== 1'b1 || dout !== 40'h42_32_22_12_02 || col_out !== 11'd2 || row_out !== 11'd4) begin
                    nf++; $display("FAIL first_window: got v=%0b d=%h c=%0d r=%0d, want 1 4232221202 2 4", validout, dout, col_out, row_out);
                end
            end
`endif
        end
    endtask

    task automatic test_rotation();
        for (int p = 35; p < 56; p++) begin
            send(1'b0);
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL rotation p=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", p, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
            if (p == 40 || p == 55) begin
                nt++;
                if (dout !== ((p == 40) ? 40'h50_40_30_20_10 : 40'h67_57_47_37_27) || validout !== 1'b1) begin
                    nf++; $display("FAIL rotation_const p=%0d: got v=%0b d=%h", p, validout, dout);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int n = 0; n < 11; n++) begin
            if (n >= 4 && n < 7) drive(1'b0, 1'b0, 8'hEE);
            else                 send(1'b0);
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL stall n=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", n, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
            if (n == 5 || n == 7) begin
                nt++;
                if (validout !== ((n == 7) ? 1'b1 : 1'b0) || dout !== ((n == 5) ? 40'h73_63_53_43_33 : 40'h74_64_54_44_34)) begin
                    nf++; $display("FAIL stall_const n=%0d: got v=%0b d=%h", n, validout, dout);
                end
            end
        end
    endtask

    task automatic test_sof_eol_resync();
        for (int n = 0; n < 7; n++) send(n == 0);
        drive(1'b1, 1'b1, 8'h00);
        gl = 0; gc = 1;
        send(1'b0);
        nt++;
        if (col_out !== 11'd1 || row_out !== 11'd0 || col_out !== exp_col || validout !== exp_valid) begin
            nf++; $display("FAIL sof_eol: got c=%0d r=%0d v=%0b, want c=1 r=0 v=%0b", col_out, row_out, validout, exp_valid);
        end
        while (!(gl == 3 && gc == 5)) send(1'b0);
        for (int n = 0; n < 33; n++) begin
            send(n == 0);
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL resync n=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", n, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
`ifndef LWB_TOP_REPLICATE_EN
            nt++;
            if (validout !== ((n == 32) ? 1'b1 : 1'b0) || (n == 32 && (col_out !== 11'd0 || row_out !== 11'd4))) begin
                nf++; $display("FAIL resync_gate n=%0d: got v=%0b c=%0d r=%0d", n, validout, col_out, row_out);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 36; n++) send(n == 0);
        reset = 1'b1;
        #1;
        nt++;
        if ({dout, validout, col_out, row_out} !== '0) begin
            nf++; $display("FAIL async_reset: got %h/%0b/%0d/%0d, want all zero", dout, validout, col_out, row_out);
        end
        #1;
        reset = 1'b0;
        model_reset();
        gl = 0; gc = 0;
        for (int n = 0; n < 33; n++) begin
            send(1'b0);
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL post_reset n=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", n, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
`ifndef LWB_TOP_REPLICATE_EN
            nt++;
            if (validout !== ((n == 32) ? 1'b1 : 1'b0)) begin
                nf++; $display("FAIL post_reset_gate n=%0d: got v=%0b", n, validout);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic v, s;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 149) == 0);
            drive(v, s, PIXEL_W'($urandom));
            nt++;
            if (validout !== exp_valid || col_out !== exp_col || row_out !== exp_row || (exp_known && dout !== exp_dout)) begin
                nf++; $display("FAIL random n=%0d: got v=%0b c=%0d r=%0d d=%h, want v=%0b c=%0d r=%0d d=%h", n, validout, col_out, row_out, dout, exp_valid, exp_col, exp_row, exp_dout);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_window();
        test_rotation();
        test_stall();
        test_sof_eol_resync();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
